// File: rtl/uart_arbiter.sv
// Two-requester round-robin arbiter in front of a UART register engine (read and write sides).
// Define UART_ARB_TIMEOUT_EN to build the WAIT-state timeout abort (TIMEOUT_CYCLES, 1..255).
module uart_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       r0_req,
  input  logic       r0_we,
  input  logic [3:0] r0_addr,
  input  logic [7:0] r0_wdata,
  input  logic       r1_req,
  input  logic       r1_we,
  input  logic [3:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r0_gnt,
  output logic       r1_gnt,
  output logic       r0_done,
  output logic       r1_done,
  output logic [7:0] r0_rdata,
  output logic [7:0] r1_rdata,
  output logic       r0_err,
  output logic       r1_err,
  output logic [3:0] eng_raddr,
  output logic       eng_ren,
  input  logic [7:0] eng_rdata,
  input  logic       eng_rdone,
  output logic [3:0] eng_waddr,
  output logic [7:0] eng_wdata,
  output logic       eng_wen,
  input  logic       eng_wdone,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       ptr;    // 1 = r1 favoured on a tie
  logic       owner;
  logic       we_q;
  logic       pick1, sel_we, eng_hit, fin;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata, rd_byte;

  assign pick1     = r1_req & (~r0_req | ptr);
  assign sel_we    = pick1 ? r1_we    : r0_we;
  assign sel_addr  = pick1 ? r1_addr  : r0_addr;
  assign sel_wdata = pick1 ? r1_wdata : r0_wdata;
  assign eng_hit   = we_q ? eng_wdone : eng_rdone;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wcnt;
  logic       fin_err;

  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    if (state == ISSUE || state == WAIT) fin = eng_hit;
    if (state == WAIT && !eng_hit && wcnt == TO_LAST) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end
  end
  assign rd_byte = (we_q | fin_err) ? 8'h00 : eng_rdata;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign fin     = (state == ISSUE || state == WAIT) && eng_hit;
  assign rd_byte = we_q ? 8'h00 : eng_rdata;
  assign r0_err  = 1'b0;
  assign r1_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      busy      <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_rdata  <= 8'h00;
      r1_rdata  <= 8'h00;
      eng_ren   <= 1'b0;
      eng_wen   <= 1'b0;
      eng_raddr <= 4'h0;
      eng_waddr <= 4'h0;
      eng_wdata <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      wcnt      <= 8'h00;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
`endif
    end else begin
      r0_gnt   <= 1'b0;
      r1_gnt   <= 1'b0;
      eng_ren  <= 1'b0;
      eng_wen  <= 1'b0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_rdata <= 8'h00;
      r1_rdata <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
`endif
      case (state)
        IDLE: if (r0_req || r1_req) begin
          owner     <= pick1;
          we_q      <= sel_we;
          eng_raddr <= sel_we ? 4'h0 : sel_addr;
          eng_waddr <= sel_we ? sel_addr : 4'h0;
          eng_wdata <= sel_we ? sel_wdata : 8'h00;
          r0_gnt    <= ~pick1;
          r1_gnt    <= pick1;
          eng_wen   <= sel_we;
          eng_ren   <= ~sel_we;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE, WAIT: if (fin) begin
          state     <= RESP;
          r0_done   <= ~owner;
          r1_done   <= owner;
          r0_rdata  <= owner ? 8'h00 : rd_byte;
          r1_rdata  <= owner ? rd_byte : 8'h00;
          eng_raddr <= 4'h0;
          eng_waddr <= 4'h0;
          eng_wdata <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
          r0_err    <= ~owner & fin_err;
          r1_err    <= owner & fin_err;
`endif
        end else begin
          state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wcnt  <= (state == ISSUE) ? 8'h00 : wcnt + 8'd1;
`endif
        end
        RESP: begin
          // Loser of this round is favoured next time both ask.
          ptr   <= ~owner;
          we_q  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_arbiter.sv
// Randomized self-checking bench for uart_arbiter against a transaction-level model
// (round-robin winner, expected latency, expected response byte).
module tb_uart_arbiter;
  logic       clk = 1'b0, rstn = 1'b0;
  logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [3:0] r0_addr = 0, r1_addr = 0;
  logic [7:0] r0_wdata = 0, r1_wdata = 0;
  logic       r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic [3:0] eng_raddr, eng_waddr;
  logic [7:0] eng_wdata;
  logic       eng_ren, eng_wen, busy;
  logic [7:0] eng_rdata = 0;
  logic       eng_rdone = 0, eng_wdone = 0;

  int n_cmp = 0, n_bad = 0;
  bit last1 = 1'b1;  // model: r1 served last, so r0 wins the first tie

  uart_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .r0_err(r0_err), .r1_err(r1_err),
    .eng_raddr(eng_raddr), .eng_ren(eng_ren), .eng_rdata(eng_rdata), .eng_rdone(eng_rdone),
    .eng_waddr(eng_waddr), .eng_wdata(eng_wdata), .eng_wen(eng_wen), .eng_wdone(eng_wdone),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] outs();
    return {busy, r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, r0_rdata, r1_rdata,
            eng_ren, eng_wen, eng_raddr, eng_waddr, eng_wdata};
  endfunction

  task automatic clear_inputs();
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_addr = 0; r1_addr = 0;
    r0_wdata = 0; r1_wdata = 0; eng_rdone = 0; eng_wdone = 0; eng_rdata = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_inputs();
    tick(); tick();
    rstn = 1;
    last1 = 1'b1;
    tick();
  endtask

  // One transaction: model picks the winner; engine answers `lat` cycles after the ISSUE cycle.
  task automatic run_txn(input logic [1:0] mask, input logic we0, input logic [3:0] a0,
                         input logic [7:0] d0, input logic we1, input logic [3:0] a1,
                         input logic [7:0] d1, input int lat, input logic [7:0] rd,
                         input bit stray);
    bit         w;
    logic       ewe;
    logic [3:0] ea;
    logic [7:0] ed, exp_rd;
    w      = (mask == 2'b11) ? !last1 : mask[1];
    ewe    = w ? we1 : we0;
    ea     = w ? a1 : a0;
    ed     = w ? d1 : d0;
    exp_rd = ewe ? 8'h00 : rd;
    r0_req = mask[0]; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_req = mask[1]; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    eng_rdone = stray; eng_wdone = stray;  // done in IDLE must be ignored
    tick();
    eng_rdone = 0; eng_wdone = 0;
    n_cmp++;
    if ({r1_gnt, r0_gnt, busy} !== {w, !w, 1'b1}) begin
      n_bad++;
      $display("FAIL gnt: got r1/r0/busy=%b%b%b want %b%b1", r1_gnt, r0_gnt, busy, w, !w);
    end
    n_cmp++;
    if ({eng_wen, eng_ren} !== {ewe, !ewe}) begin
      n_bad++;
      $display("FAIL issue_en: got wen/ren=%b%b want %b%b", eng_wen, eng_ren, ewe, !ewe);
    end
    if (w) r1_req = 0; else r0_req = 0;
    for (int k = 0; k <= lat; k++) begin
      n_cmp++;
      if ((ewe ? {eng_waddr, eng_wdata} : {eng_raddr, 8'h00}) !== {ea, ewe ? ed : 8'h00}) begin
        n_bad++;
        $display("FAIL eng_hold k=%0d: got raddr=%h waddr=%h wdata=%h want addr=%h wdata=%h",
                 k, eng_raddr, eng_waddr, eng_wdata, ea, ed);
      end
      n_cmp++;
      if ({r0_done, r1_done, r0_err, r1_err} !== 4'b0 || (k > 0 && (eng_ren | eng_wen | r0_gnt | r1_gnt))) begin
        n_bad++;
        $display("FAIL early_pulse k=%0d: got done=%b%b en=%b%b gnt=%b%b want all 0",
                 k, r0_done, r1_done, eng_ren, eng_wen, r0_gnt, r1_gnt);
      end
      if (k == lat) begin
        eng_rdata = rd;
        if (ewe) eng_wdone = 1; else eng_rdone = 1;
      end else if (stray) begin
        eng_rdata = 8'($urandom);
        if (ewe) eng_rdone = 1'($urandom); else eng_wdone = 1'($urandom);
      end
      tick();
      eng_rdone = 0; eng_wdone = 0;
    end
    n_cmp++;
    if ({r1_done, r0_done, r0_err, r1_err, busy} !== {w, !w, 2'b00, 1'b1}) begin
      n_bad++;
      $display("FAIL resp: got done r1/r0=%b%b err=%b%b busy=%b want %b%b 00 1",
               r1_done, r0_done, r0_err, r1_err, busy, w, !w);
    end
    n_cmp++;
    if ((w ? {r1_rdata, r0_rdata} : {r0_rdata, r1_rdata}) !== {exp_rd, 8'h00}) begin
      n_bad++;
      $display("FAIL rdata: got r0=%h r1=%h want owner=%h other=00", r0_rdata, r1_rdata, exp_rd);
    end
    last1 = w;
    tick();
    n_cmp++;
    if ({busy, r0_done, r1_done, r0_rdata, r1_rdata} !== 19'b0) begin
      n_bad++;
      $display("FAIL idle_after: got busy=%b done=%b%b rdata=%h/%h want 0",
               busy, r0_done, r1_done, r0_rdata, r1_rdata);
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    clear_inputs();
    r0_req = 1; r1_req = 1;
    tick();
    n_cmp++;
    if (outs() !== 41'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want 0", outs());
    end
    tick();
    n_cmp++;
    if (outs() !== 41'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0", outs());
    end
    do_reset();
  endtask

  task automatic test_no_req();
    for (int i = 0; i < 5; i++) begin
      eng_rdone = 1'($urandom); eng_wdone = 1'($urandom);
      tick();
      n_cmp++;
      if ({busy, r0_gnt, r1_gnt, r0_done, r1_done} !== 5'b0) begin
        n_bad++;
        $display("FAIL no_req: got busy=%b gnt=%b%b done=%b%b want 0",
                 busy, r0_gnt, r1_gnt, r0_done, r1_done);
      end
    end
    eng_rdone = 0; eng_wdone = 0;
  endtask

  task automatic test_read_status();
    run_txn(2'b01, 1'b0, 4'h8, 8'h00, 1'b0, 4'h0, 8'h00, 2, 8'h05, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++)
      run_txn(2'b11, 1'b0, 4'h8, 8'h00, 1'b1, 4'h4, 8'h3C, 1, 8'(8'h40 + i), 1'b0);
  endtask

  task automatic test_write_stray();
    run_txn(2'b10, 1'b0, 4'h0, 8'h00, 1'b1, 4'h4, 8'hA5, 3, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int i = 0; i < 30; i++) begin
      m = 2'($urandom_range(1, 3));
      run_txn(m, 1'($urandom), 4'($urandom_range(0, 3) << 2), 8'($urandom),
              1'($urandom), 4'($urandom_range(0, 3) << 2), 8'($urandom),
              $urandom_range(0, 5), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    r0_req = 1; r0_we = 1; r0_addr = 4'h4; r0_wdata = 8'h3C;
    tick();
    r0_req = 0;
    tick();
    rstn = 0;
    #1;
    n_cmp++;
    if (outs() !== 41'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outs: got %h want 0", outs());
    end
    tick();
    rstn = 1;
    last1 = 1'b1;
    eng_wdone = 1;
    tick();
    eng_wdone = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (outs() !== 41'b0) begin
        n_bad++;
        $display("FAIL reset_mid_late_done: got %h want 0", outs());
      end
      tick();
    end
    run_txn(2'b11, 1'b0, 4'hC, 8'h00, 1'b0, 4'h8, 8'h00, 0, 8'h77, 1'b0);
  endtask

  task automatic test_timeout();
    eng_rdata = 8'hEE;
    r1_req = 1; r1_we = 0; r1_addr = 4'h0;
    tick();
    r1_req = 0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if ({r1_done, r1_err, busy} !== 3'b001) begin
        n_bad++;
        $display("FAIL timeout_wait %0d: got done=%b err=%b busy=%b want 0 0 1", i, r1_done, r1_err, busy);
      end
    end
    tick();
    n_cmp++;
    if ({r1_done, r1_err, r1_rdata, r0_done, r0_err} !== {2'b11, 8'h00, 2'b00}) begin
      n_bad++;
      $display("FAIL timeout_resp: got done=%b err=%b rdata=%h want 1 1 00", r1_done, r1_err, r1_rdata);
    end
    last1 = 1'b1;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({busy, r0_done, r1_done, r1_err} !== 4'b1000) begin
        n_bad++;
        $display("FAIL no_timeout %0d: got busy=%b done=%b%b err=%b want 1 00 0",
                 i, busy, r0_done, r1_done, r1_err);
      end
    end
    do_reset();
`endif
    eng_rdata = 0;
  endtask

  initial begin
    test_reset();
    test_no_req();
    test_read_status();
    test_round_robin();
    test_write_stray();
    test_random();
    test_reset_mid();
    test_timeout();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
